// File: rtl/byte_frame_checksum.sv
// Frames a byte stream into FRAME_LEN-byte groups and emits a two's-complement
// checksum and XOR per frame over a valid/ready handshake.
module byte_frame_checksum #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_csum,
  output logic [7:0]       out_xor,
  output logic [CNT_W-1:0] frame_count,
  output logic [7:0]       byte_idx
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e             state_q;
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         xor_q, xor_d;
  logic [7:0]         idx_q, idx_d;
  logic [7:0]         csum_q, oxor_q;
  logic               out_valid_q;
  logic [CNT_W-1:0]   frame_count_q;
  logic               accept;
  logic               last_byte;

  assign in_ready    = (state_q != HOLD);
  assign out_valid   = out_valid_q;
  assign out_csum    = csum_q;
  assign out_xor     = oxor_q;
  assign frame_count = frame_count_q;
  assign byte_idx    = idx_q;

  // The first byte of a frame seeds the accumulators instead of adding to them.
  always_comb begin
    accept    = in_valid && in_ready;
    sum_d     = (state_q == IDLE) ? in_data : sum_q + in_data;
    xor_d     = (state_q == IDLE) ? in_data : xor_q ^ in_data;
    idx_d     = (state_q == IDLE) ? 8'd1 : idx_q + 8'd1;
    last_byte = (idx_d == 8'(FRAME_LEN));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sum_q         <= '0;
      xor_q         <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      oxor_q        <= '0;
      out_valid_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            sum_q <= sum_d;
            xor_q <= xor_d;
            idx_q <= idx_d;
            if (last_byte) begin
              state_q     <= HOLD;
              csum_q      <= ~sum_d + 8'd1;
              oxor_q      <= xor_d;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q       <= IDLE;
            out_valid_q   <= 1'b0;
            frame_count_q <= frame_count_q + CNT_W'(1);
            idx_q         <= '0;
            sum_q         <= '0;
            xor_q         <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_frame_checksum.sv
// Directed bench for byte_frame_checksum: default, FRAME_LEN=1 and CNT_W=2 instances.
module tb_byte_frame_checksum;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // default instance
  logic        m_in_valid = 1'b0, m_out_ready = 1'b0;
  logic [7:0]  m_in_data = '0;
  logic        m_in_ready, m_out_valid;
  logic [7:0]  m_csum, m_xor, m_idx;
  logic [15:0] m_cnt;

  // FRAME_LEN=1 instance
  logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [7:0]  s_in_data = '0;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_csum, s_xor, s_idx;
  logic [15:0] s_cnt;

  // CNT_W=2 instance
  logic        c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic [7:0]  c_in_data = '0;
  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_csum, c_xor, c_idx;
  logic [1:0]  c_cnt;

  byte_frame_checksum #(.FRAME_LEN(16), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_data(m_in_data),
    .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_csum(m_csum), .out_xor(m_xor), .frame_count(m_cnt), .byte_idx(m_idx));

  byte_frame_checksum #(.FRAME_LEN(1), .CNT_W(16)) u_single (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_csum(s_csum), .out_xor(s_xor), .frame_count(s_cnt), .byte_idx(s_idx));

  byte_frame_checksum #(.FRAME_LEN(16), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_ready(c_in_ready), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_csum(c_csum), .out_xor(c_xor), .frame_count(c_cnt), .byte_idx(c_idx));

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_in_ready, m_out_valid, m_csum, m_xor, m_cnt, m_idx} !== {1'b1, 1'b0, 8'h00, 8'h00, 16'h0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b vld=%b csum=%h xor=%h cnt=%0d idx=%0d, want 1 0 00 00 0 0",
               m_in_ready, m_out_valid, m_csum, m_xor, m_cnt, m_idx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    m_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_accum_%0d: got rdy=%b vld=%b, want rdy=1 vld=0", i, m_in_ready, m_out_valid);
      end
      m_in_valid = 1'b1;
      m_in_data  = 8'(i);
    end
    @(negedge clk);
    m_in_valid = 1'b0;
    n_checks++;
    if ({m_out_valid, m_in_ready, m_csum, m_xor} !== {1'b1, 1'b0, 8'h78, 8'h10}) begin
      n_fail++;
      $display("FAIL basic_result: got vld=%b rdy=%b csum=%h xor=%h, want 1 0 78 10",
               m_out_valid, m_in_ready, m_csum, m_xor);
    end
    @(negedge clk);
    n_checks++;
    if ({m_out_valid, m_in_ready, m_cnt, m_idx} !== {1'b0, 1'b1, 16'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL basic_handoff: got vld=%b rdy=%b cnt=%0d idx=%0d, want 0 1 1 0",
               m_out_valid, m_in_ready, m_cnt, m_idx);
    end
  endtask

  task automatic test_backpressure();
    m_out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      m_in_valid = 1'b1;
      m_in_data  = 8'(i);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m_in_valid = 1'b1;
      m_in_data  = 8'hAA;
      n_checks++;
      if ({m_out_valid, m_in_ready, m_csum, m_xor, m_idx} !== {1'b1, 1'b0, 8'h78, 8'h10, 8'd16}) begin
        n_fail++;
        $display("FAIL hold_stable_%0d: got vld=%b rdy=%b csum=%h xor=%h idx=%0d, want 1 0 78 10 16",
                 k, m_out_valid, m_in_ready, m_csum, m_xor, m_idx);
      end
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m_out_valid, m_in_ready, m_cnt, m_idx} !== {1'b0, 1'b1, 16'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b rdy=%b cnt=%0d idx=%0d, want 0 1 2 0",
               m_out_valid, m_in_ready, m_cnt, m_idx);
    end
  endtask

  task automatic test_gaps();
    m_out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      m_in_valid = 1'b1;
      m_in_data  = 8'hFF;
      @(negedge clk);
      m_in_valid = 1'b0;
      m_in_data  = 8'h55;
      if (i == 8) begin
        n_checks++;
        if (m_idx !== 8'd8 || m_out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL gaps_midframe: got idx=%0d vld=%b, want 8 0", m_idx, m_out_valid);
        end
      end
    end
    n_checks++;
    if ({m_out_valid, m_csum, m_xor} !== {1'b1, 8'h10, 8'h00}) begin
      n_fail++;
      $display("FAIL gaps_result: got vld=%b csum=%h xor=%h, want 1 10 00", m_out_valid, m_csum, m_xor);
    end
    m_out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d, want 3", m_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    m_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m_in_valid = 1'b1;
      m_in_data  = 8'h33;
    end
    @(negedge clk);
    m_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({m_idx, m_cnt, m_in_ready, m_out_valid} !== {8'd0, 16'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_clear: got idx=%0d cnt=%0d rdy=%b vld=%b, want 0 0 1 0",
               m_idx, m_cnt, m_in_ready, m_out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m_in_valid = 1'b1;
      m_in_data  = 8'h00;
    end
    @(negedge clk);
    m_in_valid = 1'b0;
    n_checks++;
    if ({m_out_valid, m_csum, m_xor} !== {1'b1, 8'h00, 8'h00}) begin
      n_fail++;
      $display("FAIL midreset_result: got vld=%b csum=%h xor=%h, want 1 00 00", m_out_valid, m_csum, m_xor);
    end
    @(negedge clk);
    n_checks++;
    if (m_cnt !== 16'd1 || m_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_count: got cnt=%0d vld=%b, want 1 0", m_cnt, m_out_valid);
    end
  endtask

  task automatic test_single_byte_frames();
    s_out_ready = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_data  = 8'h80;
    @(negedge clk);
    s_in_valid = 1'b0;
    n_checks++;
    if ({s_out_valid, s_in_ready, s_csum, s_xor} !== {1'b1, 1'b0, 8'h80, 8'h80}) begin
      n_fail++;
      $display("FAIL single_first: got vld=%b rdy=%b csum=%h xor=%h, want 1 0 80 80",
               s_out_valid, s_in_ready, s_csum, s_xor);
    end
    @(negedge clk);
    n_checks++;
    if ({s_out_valid, s_in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL single_bubble: got vld=%b rdy=%b, want 0 1", s_out_valid, s_in_ready);
    end
    s_in_valid = 1'b1;
    s_in_data  = 8'h01;
    @(negedge clk);
    s_in_valid = 1'b0;
    n_checks++;
    if ({s_out_valid, s_csum, s_xor} !== {1'b1, 8'hFF, 8'h01}) begin
      n_fail++;
      $display("FAIL single_second: got vld=%b csum=%h xor=%h, want 1 ff 01", s_out_valid, s_csum, s_xor);
    end
    @(negedge clk);
    n_checks++;
    if (s_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL single_count: got %0d, want 2", s_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    c_out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        c_in_valid = 1'b1;
        c_in_data  = 8'(f * 16 + i);
      end
      @(negedge clk);
      c_in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (c_cnt !== exp_cnt[f]) begin
        n_fail++;
        $display("FAIL b2b_count_%0d: got %0d, want %0d", f, c_cnt, exp_cnt[f]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_gaps();
    test_midframe_reset();
    test_single_byte_frames();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
